// File: rtl/task_sequencer.sv
// Table-driven motion step sequencer with pause, abort, optional looping and a done pulse.
// Each step runs one motor action for a duration counted in one-clock tick pulses.
module task_sequencer #(
  parameter int                            NUM_STEPS      = 4,
  parameter int                            STEP_IDX_W     = 2,
  parameter int                            TIME_W         = 8,
  parameter logic [NUM_STEPS*TIME_W-1:0]   STEP_DURATIONS = {8'd5, 8'd3, 8'd5, 8'd3},
  parameter logic [NUM_STEPS*2-1:0]        STEP_ACTIONS   = {2'b10, 2'b01, 2'b10, 2'b01},
  parameter bit                            LOOP           = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  oneHz_enable,
  input  logic                  pause,
  input  logic                  abort,
  output logic                  enable_forward,
  output logic                  enable_left,
  output logic                  enable_right,
  output logic [1:0]            state,
  output logic [STEP_IDX_W-1:0] step_index,
  output logic [TIME_W-1:0]     remaining,
  output logic                  done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [STEP_IDX_W-1:0] FIRST_STEP = {STEP_IDX_W{1'b0}};
  localparam logic [STEP_IDX_W-1:0] LAST_STEP  = STEP_IDX_W'(NUM_STEPS - 1);
  localparam logic [STEP_IDX_W-1:0] STEP_ONE   = STEP_IDX_W'(1);
  localparam logic [TIME_W-1:0]     TIME_ZERO  = {TIME_W{1'b0}};
  localparam logic [TIME_W-1:0]     TIME_ONE   = TIME_W'(1);

  // A zero-length table entry still occupies one tick
  function automatic logic [TIME_W-1:0] step_duration(input logic [STEP_IDX_W-1:0] idx);
    logic [TIME_W-1:0] dur_v;
    dur_v = STEP_DURATIONS[int'(idx)*TIME_W +: TIME_W];
    if (dur_v == TIME_ZERO) begin
      return TIME_ONE;
    end else begin
      return dur_v;
    end
  endfunction

  // Returns {forward, left, right}
  function automatic logic [2:0] decode_action(input logic [STEP_IDX_W-1:0] idx);
    case (STEP_ACTIONS[int'(idx)*2 +: 2])
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  logic [1:0]            next_state_s;
  logic [STEP_IDX_W-1:0] next_step_s;
  logic [TIME_W-1:0]     next_remaining_s;
  logic                  next_done_s;
  logic [2:0]            next_enables_s;

  // Next-state logic; abort outranks pause, pause outranks tick, tick outranks start
  always_comb begin
    next_state_s     = state;
    next_step_s      = step_index;
    next_remaining_s = remaining;
    next_done_s      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!abort && start) begin
          next_state_s     = ST_RUN;
          next_step_s      = FIRST_STEP;
          next_remaining_s = step_duration(FIRST_STEP);
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          next_state_s     = ST_IDLE;
          next_step_s      = FIRST_STEP;
          next_remaining_s = TIME_ZERO;
        end else if (pause) begin
          next_state_s = ST_PAUSE;
        end else if (oneHz_enable) begin
          if (remaining > TIME_ONE) begin
            next_remaining_s = remaining - TIME_ONE;
          end else if (step_index != LAST_STEP) begin
            next_step_s      = step_index + STEP_ONE;
            next_remaining_s = step_duration(step_index + STEP_ONE);
          end else if (LOOP) begin
            next_step_s      = FIRST_STEP;
            next_remaining_s = step_duration(FIRST_STEP);
            next_done_s      = !done;
          end else begin
            next_state_s     = ST_DONE;
            next_remaining_s = TIME_ZERO;
            next_done_s      = !done;
          end
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          next_state_s     = ST_IDLE;
          next_step_s      = FIRST_STEP;
          next_remaining_s = TIME_ZERO;
        end else if (!pause) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (abort) begin
          next_state_s     = ST_IDLE;
          next_step_s      = FIRST_STEP;
          next_remaining_s = TIME_ZERO;
        end else if (start) begin
          next_state_s     = ST_RUN;
          next_step_s      = FIRST_STEP;
          next_remaining_s = step_duration(FIRST_STEP);
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s     = ST_IDLE;
        next_step_s      = FIRST_STEP;
        next_remaining_s = TIME_ZERO;
      end
    endcase

    if (next_state_s == ST_RUN) begin
      next_enables_s = decode_action(next_step_s);
    end else begin
      next_enables_s = 3'b000;
    end
  end

  // Output registers; enables follow the step they will be driving
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      step_index     <= FIRST_STEP;
      remaining      <= TIME_ZERO;
      done           <= 1'b0;
      enable_forward <= 1'b0;
      enable_left    <= 1'b0;
      enable_right   <= 1'b0;
    end else begin
      state          <= next_state_s;
      step_index     <= next_step_s;
      remaining      <= next_remaining_s;
      done           <= next_done_s;
      enable_forward <= next_enables_s[2];
      enable_left    <= next_enables_s[1];
      enable_right   <= next_enables_s[0];
    end
  end

endmodule

// File: tb/tb_task_sequencer.sv
// Bench for task_sequencer: three instances (plain, looping, zero-duration step) share
// one stimulus stream and are compared every cycle against an elapsed-tick reference model.
module tb_task_sequencer;

  logic clk = 1'b0;
  logic reset, start, oneHz_enable, pause, abort;

  logic [1:0] st [3];
  logic [1:0] stp [3];
  logic [7:0] rem [3];
  logic       fwd [3], lft [3], rgt [3], dn [3];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  task_sequencer #(.NUM_STEPS(3), .STEP_IDX_W(2), .TIME_W(8),
    .STEP_DURATIONS({8'd1, 8'd3, 8'd2}), .STEP_ACTIONS({2'b01, 2'b10, 2'b01}), .LOOP(1'b0))
  dut_a (.clk(clk), .reset(reset), .start(start), .oneHz_enable(oneHz_enable), .pause(pause),
    .abort(abort), .enable_forward(fwd[0]), .enable_left(lft[0]), .enable_right(rgt[0]),
    .state(st[0]), .step_index(stp[0]), .remaining(rem[0]), .done(dn[0]));

  task_sequencer #(.NUM_STEPS(3), .STEP_IDX_W(2), .TIME_W(8),
    .STEP_DURATIONS({8'd1, 8'd3, 8'd2}), .STEP_ACTIONS({2'b01, 2'b10, 2'b01}), .LOOP(1'b1))
  dut_l (.clk(clk), .reset(reset), .start(start), .oneHz_enable(oneHz_enable), .pause(pause),
    .abort(abort), .enable_forward(fwd[1]), .enable_left(lft[1]), .enable_right(rgt[1]),
    .state(st[1]), .step_index(stp[1]), .remaining(rem[1]), .done(dn[1]));

  task_sequencer #(.NUM_STEPS(3), .STEP_IDX_W(2), .TIME_W(8),
    .STEP_DURATIONS({8'd1, 8'd0, 8'd2}), .STEP_ACTIONS({2'b01, 2'b10, 2'b01}), .LOOP(1'b0))
  dut_z (.clk(clk), .reset(reset), .start(start), .oneHz_enable(oneHz_enable), .pause(pause),
    .abort(abort), .enable_forward(fwd[2]), .enable_left(lft[2]), .enable_right(rgt[2]),
    .state(st[2]), .step_index(stp[2]), .remaining(rem[2]), .done(dn[2]));

  // Reference model: mode plus ticks elapsed since sequence start
  int cum [3][4];
  int act_m [3];
  int loop_m [3];
  int m_mode [3];
  int m_el [3];
  int m_done [3];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int step_of(input int k, input int el);
    for (int i = 0; i < 3; i++) begin
      if (el < cum[k][i+1]) return i;
    end
    return 2;
  endfunction

  function automatic int expected(input int k);
    int s, r, f, l, g, a;
    s = 0; r = 0; f = 0; l = 0; g = 0;
    if (m_mode[k] == 3) begin
      s = 2;
    end else if (m_mode[k] != 0) begin
      s = step_of(k, m_el[k]);
      r = cum[k][s+1] - m_el[k];
    end
    if (m_mode[k] == 1) begin
      a = (act_m[k] >> (2*s)) & 3;
      f = (a == 1) ? 1 : 0;
      l = (a == 2) ? 1 : 0;
      g = (a == 3) ? 1 : 0;
    end
    return m_mode[k]*16384 + s*4096 + r*16 + f*8 + l*4 + g*2 + m_done[k];
  endfunction

  function automatic int observed(input int k);
    return int'({st[k], stp[k], rem[k], fwd[k], lft[k], rgt[k], dn[k]});
  endfunction

  task automatic model_update(input int k, input bit r, input bit s, input bit p,
                              input bit a, input bit t);
    int total;
    total = cum[k][3];
    m_done[k] = 0;
    if (r) begin
      m_mode[k] = 0; m_el[k] = 0;
    end else begin
      case (m_mode[k])
        0: if (!a && s) begin m_mode[k] = 1; m_el[k] = 0; end
        1: begin
          if (a) begin
            m_mode[k] = 0; m_el[k] = 0;
          end else if (p) begin
            m_mode[k] = 2;
          end else if (t) begin
            m_el[k]++;
            if (m_el[k] == total) begin
              m_done[k] = 1;
              if (loop_m[k] != 0) m_el[k] = 0;
              else m_mode[k] = 3;
            end
          end
        end
        2: begin
          if (a) begin m_mode[k] = 0; m_el[k] = 0; end
          else if (!p) m_mode[k] = 1;
        end
        default: begin
          if (a) begin m_mode[k] = 0; m_el[k] = 0; end
          else if (s) begin m_mode[k] = 1; m_el[k] = 0; end
        end
      endcase
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit p, input bit a, input bit t);
    reset = r; start = s; pause = p; abort = a; oneHz_enable = t;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k, r, s, p, a, t);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_eq($sformatf("model_dut%0d", k), observed(k), expected(k));
  endtask

  task automatic tick_wait(input int n, input bit p);
    repeat (n - 1) cycle(1'b0, 1'b0, p, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, p, 1'b0, 1'b1);
  endtask

  initial begin
    int eff [3][3];
    bit pause_lvl;
    eff[0] = '{2, 3, 1};
    eff[1] = '{2, 3, 1};
    eff[2] = '{2, 1, 1};
    for (int k = 0; k < 3; k++) begin
      cum[k][0] = 0;
      for (int i = 0; i < 3; i++) cum[k][i+1] = cum[k][i] + eff[k][i];
      act_m[k] = 1 + (2 << 2) + (1 << 4);
      loop_m[k] = (k == 1) ? 1 : 0;
      m_mode[k] = 0; m_el[k] = 0; m_done[k] = 0;
    end

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check_eq("reset_state", int'(st[0]), 0);
    check_eq("reset_remaining", int'(rem[0]), 0);

    cycle(0, 1, 0, 0, 0);
    check_eq("start_state", int'(st[0]), 1);
    check_eq("start_step", int'(stp[0]), 0);
    check_eq("start_remaining", int'(rem[0]), 2);
    check_eq("start_forward", int'(fwd[0]), 1);

    tick_wait(100, 0);
    check_eq("tick1_remaining", int'(rem[0]), 1);
    tick_wait(100, 0);
    check_eq("tick2_step", int'(stp[0]), 1);
    check_eq("tick2_left", int'(lft[0]), 1);
    check_eq("tick2_remaining", int'(rem[0]), 3);
    tick_wait(100, 0);
    check_eq("tick3_remaining", int'(rem[0]), 2);
    check_eq("zero_dur_step", int'(stp[2]), 2);
    check_eq("zero_dur_remaining", int'(rem[2]), 1);

    cycle(0, 0, 1, 0, 1);
    check_eq("pause_tick_state", int'(st[0]), 2);
    check_eq("pause_tick_remaining", int'(rem[0]), 2);
    check_eq("pause_left_off", int'(lft[0]), 0);
    repeat (3) tick_wait(100, 1);
    check_eq("paused_remaining", int'(rem[0]), 2);
    cycle(0, 0, 0, 0, 0);
    check_eq("resume_state", int'(st[0]), 1);
    check_eq("resume_left", int'(lft[0]), 1);

    tick_wait(100, 0);
    check_eq("tick4_step", int'(stp[0]), 1);
    check_eq("zero_dur_done", int'(dn[2]), 1);
    tick_wait(100, 0);
    check_eq("tick5_step", int'(stp[0]), 2);
    check_eq("tick5_forward", int'(fwd[0]), 1);
    tick_wait(100, 0);
    check_eq("tick6_state", int'(st[0]), 3);
    check_eq("tick6_done", int'(dn[0]), 1);
    check_eq("tick6_forward_off", int'(fwd[0]), 0);
    check_eq("loop_state", int'(st[1]), 1);
    check_eq("loop_step", int'(stp[1]), 0);
    check_eq("loop_remaining", int'(rem[1]), 2);
    check_eq("loop_done", int'(dn[1]), 1);
    cycle(0, 0, 0, 0, 0);
    check_eq("done_width", int'(dn[0]), 0);

    for (int i = 0; i < 6; i++) tick_wait(20, 0);
    check_eq("loop_second_done", int'(dn[1]), 1);

    cycle(0, 1, 0, 0, 0);
    check_eq("start_in_run_step", int'(stp[1]), 0);
    check_eq("start_in_run_remaining", int'(rem[1]), 2);

    tick_wait(10, 0);
    tick_wait(10, 0);
    check_eq("pre_abort_step", int'(stp[0]), 1);
    cycle(0, 0, 0, 1, 0);
    check_eq("abort_state", int'(st[0]), 0);
    check_eq("abort_remaining", int'(rem[0]), 0);
    check_eq("abort_done", int'(dn[0]), 0);
    cycle(0, 1, 0, 0, 0);
    check_eq("restart_remaining", int'(rem[0]), 2);

    tick_wait(10, 0);
    cycle(1, 1, 0, 0, 0);
    check_eq("reset_with_start", int'(st[0]), 0);

    pause_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29, 0) == 0) pause_lvl = ~pause_lvl;
      cycle($urandom_range(199, 0) == 0, $urandom_range(7, 0) == 0, pause_lvl,
            $urandom_range(59, 0) == 0, $urandom_range(2, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
